aes_inv_key_stream: RTL and testbench

//  Reverse AES-128 key scheduler: takes the final (round-10) key and regenerates round keys 10,9,...,0 one per handshake beat.

---
 rtl/aes_inv_key_stream.sv | 137 +++++++++++++
 tb/tb_aes_inv_key_stream.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_stream.sv
// Reverse AES-128 key schedule: starting from the round-10 key, emits round keys
// in decryption order (10..0) one per accepted beat, undoing one expansion step per cycle.
module aes_inv_key_stream #(
    parameter bit EMIT_LAST_KEY = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] last_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         out_last,
    output logic         busy
);

    // FIPS-197 forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state_q;
    logic [127:0]  round_key_q;
    logic [3:0]    round_idx_q;
    logic          out_valid_q;
    logic          out_last_q;
    logic [127:0]  step_in;
    logic [3:0]    step_r;
    logic [127:0]  step_d;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Recovers round key r-1 from round key r: the last three words fall out of the
    // chained XORs directly, word 0 needs the g() function of the recovered word 3.
    function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] p0, p1, p2, p3, t;
        p3 = k[31:0]   ^ k[63:32];
        p2 = k[63:32]  ^ k[95:64];
        p1 = k[95:64]  ^ k[127:96];
        t  = {p3[23:0], p3[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        p0 = k[127:96] ^ t ^ {rcon(r), 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    // One shared step datapath: fed by the incoming key at load, by the held key while streaming.
    always_comb begin
        step_in = round_key_q;
        step_r  = round_idx_q;
        if (state_q == IDLE) begin
            step_in = last_key;
            step_r  = 4'd10;
        end
        step_d = inv_step(step_in, step_r);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            round_key_q <= '0;
            round_idx_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q     <= STREAM;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        round_key_q <= EMIT_LAST_KEY ? last_key : step_d;
                        round_idx_q <= EMIT_LAST_KEY ? 4'd10 : 4'd9;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (round_idx_q == 4'd0) begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            round_key_q <= step_d;
                            round_idx_q <= round_idx_q - 4'd1;
                            out_last_q  <= (round_idx_q == 4'd1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign round_key = round_key_q;
    assign round_idx = round_idx_q;

endmodule

// File: tb/tb_aes_inv_key_stream.sv
// Bench for aes_inv_key_stream: forward-expands cipher keys in a reference model and
// checks the reverse stream from both parameterisations.
module tb_aes_inv_key_stream;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, out_ready = 1'b1;
    logic [127:0] last_key = '0;
    logic         in_ready, out_valid, out_last, busy;
    logic [127:0] round_key;
    logic [3:0]   round_idx;

    logic         in_valid0 = 1'b0, out_ready0 = 1'b1;
    logic [127:0] last_key0 = '0;
    logic         in_ready0, out_valid0, out_last0, busy0;
    logic [127:0] round_key0;
    logic [3:0]   round_idx0;

    int compared = 0;
    int mismatched = 0;
    logic [127:0] rk  [0:10];
    logic [127:0] got [0:10];

    always #5 clk = ~clk;

    aes_inv_key_stream #(.EMIT_LAST_KEY(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .last_key(last_key),
        .out_valid(out_valid), .out_ready(out_ready), .round_key(round_key),
        .round_idx(round_idx), .out_last(out_last), .busy(busy)
    );

    aes_inv_key_stream #(.EMIT_LAST_KEY(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .last_key(last_key0),
        .out_valid(out_valid0), .out_ready(out_ready0), .round_key(round_key0),
        .round_idx(round_idx0), .out_last(out_last0), .busy(busy0)
    );

    function automatic logic [31:0] subw(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            r[8*i +: 8] = SBOX[2040 - 8*b +: 8];
        end
        return r;
    endfunction

    // Straightforward FIPS-197 forward key expansion into rk[0..10].
    function automatic void expand(input logic [127:0] ck);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [127:0] k);
        @(negedge clk);
        chk("load_in_ready", in_ready, 1);
        in_valid = 1'b1;
        last_key = k;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Consumes beats 10 down to stop, comparing every cycle the beat is presented.
    task automatic stream(input int stop, input bit bp);
        int idx;
        int cyc;
        idx = 10;
        cyc = 0;
        while (idx >= stop && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                chk("key", round_key, rk[idx]);
                chk("idx", round_idx, idx[3:0]);
                chk("last", out_last, idx == 0);
                chk("busy", busy, 1);
                got[idx] = round_key;
                out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_ready) idx--;
            end
        end
        out_ready = 1'b1;
        if (cyc >= 400) begin
            compared++;
            mismatched++;
            $error("FAIL stream_timeout: observed idx %0d expected %0d", idx, stop - 1);
        end
    endtask

    task automatic check_idle;
        @(negedge clk);
        chk("idle_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_last", out_last, 0);
    endtask

    initial begin
        int idx0, beats0, cyc0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_key", round_key, 0);
        chk("rst_idx", round_idx, 0);
        chk("rst_last", out_last, 0);
        rst = 1'b0;

        // T1 + T3: FIPS-197 vector with a second load already waiting on in_valid
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("model_rk10", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        load(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        in_valid = 1'b1;
        last_key = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        stream(0, 1'b0);
        chk("t1_idx9", got[9], 128'hac7766f319fadc2128d12941575c006e);
        chk("t1_idx0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check_idle;
        @(posedge clk);
        #1 in_valid = 1'b0;
        expand(128'h0);
        stream(0, 1'b0);
        chk("t3_idx10", got[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        chk("t3_idx0", got[0], 128'h0);
        check_idle;

        // T2: backpressure on the FIPS-197 vector
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        load(rk[10]);
        stream(0, 1'b1);
        check_idle;

        // T4: async reset mid-stream, then a fresh load
        load(rk[10]);
        stream(6, 1'b0);
        @(posedge clk);
        #1 chk("t4_pre_idx", round_idx, 5);
        #1 rst = 1'b1;
        #1;
        chk("t4_valid", out_valid, 0);
        chk("t4_in_ready", in_ready, 1);
        chk("t4_busy", busy, 0);
        chk("t4_key", round_key, 0);
        chk("t4_idx", round_idx, 0);
        chk("t4_last", out_last, 0);
        @(negedge clk);
        rst = 1'b0;
        load(rk[10]);
        stream(0, 1'b0);
        check_idle;

        // T5: EMIT_LAST_KEY=0 instance starts at round 9
        @(negedge clk);
        in_valid0 = 1'b1;
        last_key0 = rk[10];
        @(posedge clk);
        #1 in_valid0 = 1'b0;
        idx0 = 9;
        beats0 = 0;
        cyc0 = 0;
        while (idx0 >= 0 && cyc0 < 100) begin
            @(negedge clk);
            cyc0++;
            if (out_valid0) begin
                chk("t5_key", round_key0, rk[idx0]);
                chk("t5_idx", round_idx0, idx0[3:0]);
                chk("t5_last", out_last0, idx0 == 0);
                beats0++;
                idx0--;
            end
        end
        chk("t5_beats", beats0, 10);
        @(negedge clk);
        chk("t5_idle_valid", out_valid0, 0);
        chk("t5_idle_in_ready", in_ready0, 1);

        // T6: random cipher keys, random backpressure
        for (int n = 0; n < 6; n++) begin
            expand({$urandom, $urandom, $urandom, $urandom});
            load(rk[10]);
            stream(0, n[0]);
            check_idle;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
